// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / hazard unit: register address
// width, the per-stage tag carried down the pipeline, and the width of a
// forward-select field.
package fwd_pkg;

  localparam int REG_ADDR_W = 5;

  // One pipeline slot: which register (if any) this instruction produces.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '0;

  // Width of a select field able to encode 0 (register file) .. stages.
  function automatic int sel_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// Tag shift register: entry 0 is the instruction in EX, entry j is j stages
// past EX. Every cycle the whole pipe advances by one; entry 0 receives the
// ID tag when an instruction issues, otherwise a bubble.
module fwd_tag_pipe
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_issue,
  input  tag_t             i_tag,
  output tag_t [DEPTH-1:0] o_tags
);

  tag_t [DEPTH-1:0] r_tags;

  // Shift the tags one stage per cycle, inserting a bubble when nothing issues.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tags <= '0;
    end else begin
      r_tags[0] <= i_issue ? i_tag : TAG_BUBBLE;
      for (int j = 1; j < DEPTH; j++) begin
        r_tags[j] <= r_tags[j-1];
      end
    end
  end

  assign o_tags = r_tags;

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard unit.
// Tracks the destination of every instruction from EX down to the last
// forwarding stage, selects the youngest matching producer for each EX
// source operand, and stalls ID while a load result is not yet forwardable.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.
//
// Handshake: id_valid qualifies the ID fields. The ID instruction moves into
// EX on a cycle with id_valid && !stall && !flush; while stall is high the
// front end holds PC and IF/ID unchanged and a bubble enters EX. flush kills
// the ID instruction and always wins over stall.
module forwarding_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int FWD_STAGES = 2,
  parameter  int LOAD_LAT   = 1,
  localparam int SEL_W      = sel_w(FWD_STAGES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_dst_addr,
  input  logic                          id_reg_write,
  input  logic                          id_mem_read,
  input  logic                          flush,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel,
  output logic [31:0]                   perf_stall_cnt,
  output logic [31:0]                   perf_fwd_cnt
);

  localparam int DEPTH = FWD_STAGES + 1;

  tag_t [DEPTH-1:0]              w_tags;
  tag_t                          w_id_tag;
  logic                          w_issue;
  logic                          w_hazard;
  logic [NUM_SRC*SEL_W-1:0]      w_fwd_sel;
  logic                          w_unused_tags;
  logic [NUM_SRC*REG_ADDR_W-1:0] r_ex_src;
  logic [NUM_SRC-1:0]            r_ex_used;

  assign w_issue  = id_valid & ~stall & ~flush;
  assign w_id_tag = '{valid: 1'b1, rd: id_dst_addr,
                      reg_write: id_reg_write, is_load: id_mem_read};

  fwd_tag_pipe #(
    .DEPTH (DEPTH)
  ) u_tag_pipe (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_issue (w_issue),
    .i_tag   (w_id_tag),
    .o_tags  (w_tags)
  );

  // Capture the EX instruction's source operands alongside entry 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_src  <= '0;
      r_ex_used <= '0;
    end else if (w_issue) begin
      r_ex_src  <= id_src_addr;
      r_ex_used <= id_src_used;
    end else begin
      r_ex_src  <= '0;
      r_ex_used <= '0;
    end
  end

  // Youngest producer wins: scan oldest to youngest so the smallest j sticks.
  always_comb begin
    w_fwd_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int j = FWD_STAGES; j >= 1; j--) begin
        if (w_tags[0].valid && r_ex_used[k] &&
            (r_ex_src[k*REG_ADDR_W +: REG_ADDR_W] != '0) &&
            w_tags[j].valid && w_tags[j].reg_write &&
            (w_tags[j].rd == r_ex_src[k*REG_ADDR_W +: REG_ADDR_W])) begin
          w_fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(j);
        end
      end
    end
  end

  // Load-use hazard: a used ID source needs a load still inside the
  // not-yet-forwardable window (entries 0 .. LOAD_LAT-1).
  always_comb begin
    w_hazard = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int j = 0; j < LOAD_LAT; j++) begin
        if (id_src_used[k] &&
            (id_src_addr[k*REG_ADDR_W +: REG_ADDR_W] != '0) &&
            w_tags[j].valid && w_tags[j].is_load && w_tags[j].reg_write &&
            (w_tags[j].rd == id_src_addr[k*REG_ADDR_W +: REG_ADDR_W])) begin
          w_hazard = 1'b1;
        end
      end
    end
  end

  // Reset gates stall directly so it drops in the same cycle reset rises.
  assign stall      = id_valid & ~flush & ~reset & w_hazard;
  assign ex_fwd_sel = w_fwd_sel;

  // Some tag bits (e.g. is_load of older entries) are never read for a given
  // parameter set; fold them so they are visibly consumed.
  assign w_unused_tags = ^w_tags;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;

  // Saturating event counters for stall cycles and forwarding cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if ((w_fwd_sel != '0) && (r_fwd_cnt != 32'hFFFF_FFFF)) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_fwd_cnt   = r_fwd_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: directed hazard scenarios followed by a
// randomized instruction stream, all checked against an in-flight
// instruction queue model.
module tb_forwarding_hazard_unit;

  localparam int NUM_SRC    = 2;
  localparam int FWD_STAGES = 2;
  localparam int LOAD_LAT   = 1;
  localparam int SEL_W      = 2;

  // Clock / reset and DUT signals
  logic                     clk;
  logic                     reset;
  logic                     id_valid;
  logic [NUM_SRC*5-1:0]     id_src_addr;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [4:0]               id_dst_addr;
  logic                     id_reg_write;
  logic                     id_mem_read;
  logic                     flush;
  logic                     stall;
  logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel;
  logic [31:0]              perf_stall_cnt;
  logic [31:0]              perf_fwd_cnt;

  int n_vec = 0;
  int n_err = 0;

  forwarding_hazard_unit #(
    .NUM_SRC    (NUM_SRC),
    .FWD_STAGES (FWD_STAGES),
    .LOAD_LAT   (LOAD_LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_src_addr    (id_src_addr),
    .id_src_used    (id_src_used),
    .id_dst_addr    (id_dst_addr),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .flush          (flush),
    .stall          (stall),
    .ex_fwd_sel     (ex_fwd_sel),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of instructions, index 0 = EX, j = j stages later
  typedef struct {
    bit valid;
    int rd;
    bit wr;
    bit ld;
    int s0;
    int s1;
    bit u0;
    bit u1;
  } m_instr_t;

  m_instr_t    m_pipe[$];
  logic [31:0] m_stall_cnt;
  logic [31:0] m_fwd_cnt;
  bit          e_stall;
  logic [3:0]  e_sel;

  function automatic m_instr_t bubble();
    m_instr_t b;
    b = '{valid: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0, s0: 0, s1: 0, u0: 1'b0, u1: 1'b0};
    return b;
  endfunction

  task automatic model_reset();
    m_pipe.delete();
    for (int j = 0; j <= FWD_STAGES; j++) m_pipe.push_back(bubble());
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
  endtask

  function automatic int exp_sel_one(int src, bit used);
    if (!m_pipe[0].valid || !used || src == 0) return 0;
    for (int j = 1; j <= FWD_STAGES; j++)
      if (m_pipe[j].valid && m_pipe[j].wr && m_pipe[j].rd == src) return j;
    return 0;
  endfunction

  function automatic bit exp_stall_f();
    int a0;
    int a1;
    a0 = int'(id_src_addr[4:0]);
    a1 = int'(id_src_addr[9:5]);
    if (reset || !id_valid || flush) return 1'b0;
    for (int j = 0; j < LOAD_LAT; j++) begin
      if (m_pipe[j].valid && m_pipe[j].ld && m_pipe[j].wr && m_pipe[j].rd != 0) begin
        if (id_src_used[0] && a0 == m_pipe[j].rd) return 1'b1;
        if (id_src_used[1] && a1 == m_pipe[j].rd) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_id(bit v, int dst, bit wr, bit ld, int s0, int s1, bit u0, bit u1);
    id_valid     = v;
    id_dst_addr  = 5'(dst);
    id_reg_write = wr;
    id_mem_read  = ld;
    id_src_addr  = {5'(s1), 5'(s0)};
    id_src_used  = {u1, u0};
  endtask

  task automatic nop();
    set_id(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // Settle combinational outputs after the negedge and compare with the model
  task automatic eval();
    #2;
    e_stall = exp_stall_f();
    e_sel   = {2'(exp_sel_one(m_pipe[0].s1, m_pipe[0].u1)),
               2'(exp_sel_one(m_pipe[0].s0, m_pipe[0].u0))};
    check("stall", 32'(stall), 32'(e_stall));
    check("fwd_sel", 32'(ex_fwd_sel), 32'(e_sel));
    check("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
    check("perf_fwd_cnt", perf_fwd_cnt, m_fwd_cnt);
  endtask

  // Advance one clock and move the model accordingly
  task automatic tick();
    m_instr_t cur;
    bit       issue;
    cur = '{valid: 1'b1, rd: int'(id_dst_addr), wr: id_reg_write, ld: id_mem_read,
            s0: int'(id_src_addr[4:0]), s1: int'(id_src_addr[9:5]),
            u0: id_src_used[0], u1: id_src_used[1]};
    issue = id_valid && !e_stall && !flush;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
`ifdef FWD_PERF_CNT_EN
      if (e_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
      if (e_sel != 0 && m_fwd_cnt != 32'hFFFF_FFFF) m_fwd_cnt = m_fwd_cnt + 1;
`endif
      m_pipe.push_front(issue ? cur : bubble());
      void'(m_pipe.pop_back());
    end
    @(negedge clk);
  endtask

  task automatic step();
    eval();
    tick();
  endtask

  initial begin
    bit hold;
    reset = 1'b1;
    flush = 1'b0;
    nop();
    model_reset();
    e_stall = 1'b0;
    e_sel   = '0;

    // Reset state
    @(negedge clk);
    eval();
    tick();
    reset = 1'b0;

    // add r3,r1,r2 ; sub r4,r3,r5 -> src0 forwards from stage 1
    set_id(1, 3, 1, 0, 1, 2, 1, 1); step();
    set_id(1, 4, 1, 0, 3, 5, 1, 1); step();
    nop(); eval();
    check("b2b_sel", 32'(ex_fwd_sel), 32'h1);
    tick();

    // add r3 ; add r3 ; or r6,r3,r3 -> both sources pick the youngest
    set_id(1, 3, 1, 0, 1, 2, 1, 1); step();
    set_id(1, 3, 1, 0, 4, 5, 1, 1); step();
    set_id(1, 6, 1, 0, 3, 3, 1, 1); step();
    nop(); eval();
    check("double_prod_sel", 32'(ex_fwd_sel), 32'h5);
    tick();

    // lw r2 ; add r7,r2,r1 -> one stall cycle then forward from stage 2
    set_id(1, 2, 1, 1, 8, 9, 1, 0); step();
    set_id(1, 7, 1, 0, 2, 1, 1, 1); eval();
    check("load_use_stall", 32'(stall), 32'h1);
    tick();
    eval();
    check("load_use_release", 32'(stall), 32'h0);
    tick();
    nop(); eval();
    check("load_use_sel", 32'(ex_fwd_sel), 32'h2);
    tick();

    // lw r0 ; add r1,r0,r0 -> register zero never stalls or forwards
    set_id(1, 0, 1, 1, 8, 9, 1, 0); step();
    set_id(1, 1, 1, 0, 0, 0, 1, 1); eval();
    check("r0_stall", 32'(stall), 32'h0);
    tick();
    nop(); eval();
    check("r0_sel", 32'(ex_fwd_sel), 32'h0);
    tick();

    // lw r2 ; add r7,r2,r1 with flush -> no stall, bubble in EX
    set_id(1, 2, 1, 1, 8, 9, 1, 0); step();
    set_id(1, 7, 1, 0, 2, 1, 1, 1); flush = 1'b1; eval();
    check("flush_stall", 32'(stall), 32'h0);
    tick();
    flush = 1'b0; nop(); eval();
    check("flush_bubble_sel", 32'(ex_fwd_sel), 32'h0);
    tick();

    // Three load-use pairs, three stall cycles
    for (int n = 0; n < 3; n++) begin
      set_id(1, 2, 1, 1, 8, 9, 1, 0); step();
      set_id(1, 7, 1, 0, 2, 1, 1, 1); step();
      step();
    end
    nop(); step();

    // Reset asserted while a stall is active
    set_id(1, 2, 1, 1, 8, 9, 1, 0); step();
    set_id(1, 7, 1, 0, 2, 1, 1, 1); eval();
    check("pre_reset_stall", 32'(stall), 32'h1);
    reset = 1'b1;
    #1;
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_stall_cnt", perf_stall_cnt, 32'h0);
    check("reset_fwd_cnt", perf_fwd_cnt, 32'h0);
    model_reset();
    e_stall = 1'b0;
    tick();
    reset = 1'b0;
    set_id(1, 5, 1, 0, 2, 7, 1, 1); step();
    nop(); eval();
    check("post_reset_sel", 32'(ex_fwd_sel), 32'h0);
    tick();

    // Randomized instruction stream on a small register window
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        set_id($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
               $urandom_range(0, 9) < 3, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end
      flush = ($urandom_range(0, 9) == 0);
      eval();
      hold = e_stall;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
